seq_frac_mult: RTL and testbench
================================

// Module: seq_frac_mult
// PURPOSE
//  Parametrised iterative shift-add multiplier for significands (1.x fixed point, WIDTH bits).
//  Replaces the fixed 24-bit free-running multiplier in the root/power datapaths.
//  Adds a start/busy/done handshake and back-to-back operation.
//  Delivers a normalised product with a carry (exponent +1) flag; shares one adder across WIDTH cycles.
// PARAMETERS
//  WIDTH  24  significand width incl. hidden bit (11 half, 24 single, 53 double); min 2
// PORTS
//  CLK    in   1        clock, rising edge
//  RST    in   1        reset, asynchronous, active-low
//  start  in   1        request; sampled only when busy==0
//  A      in   WIDTH    multiplicand significand, captured on accepted start
//  B      in   WIDTH    multiplier significand, captured on accepted start
//  busy   out  1        iteration in progress
//  done   out  1        result valid; level, held until next accepted start
//  frac   out  WIDTH    normalised product significand (truncated)
//  carry  out  1        product >= 2.0; caller increments exponent
//  sticky out  1        OR of discarded product bits (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, frac=0, carry=0, sticky=0; accumulator and counter cleared.
//  - FSM IDLE -> RUN on start; RUN -> DONE when counter reaches 0; DONE -> RUN on start; no exit to IDLE except reset.
//  - Accept (cycle 0): start=1 and busy=0.
//    - Latch A and B; acc<=0; cnt<=WIDTH; busy=1 from cycle 1; done drops in cycle 1.
//  - RUN step, MSB-first: acc <= (acc<<1) + (a_sh[WIDTH-1] ? B : 0); a_sh <= a_sh<<1; cnt <= cnt-1.
//  - acc is 2*WIDTH bits wide and never truncated; after WIDTH steps acc == A*B exactly.
//  - Latency: done=1 and busy=0 from cycle WIDTH+1; throughput 1 result per WIDTH+1 cycles.
//  - Normalisation is registered and valid while done=1:
//    - P[2W-1]=1: frac=P[2W-1:W], carry=1, dropped bits P[W-1:0].
//    - P[2W-1]=0: frac=P[2W-2:W-1], carry=0, dropped bits P[W-2:0].
//  - Outputs frac, carry and sticky hold their value while done=1 and are not cleared by a new start.
//    They change only when the next result completes.
//  - start while busy=1 is ignored; it is not queued and operands are not re-sampled.
//  - start in the same cycle done rises (DONE state): accepted; done falls next cycle.
//  - A or B zero: full WIDTH iterations still run; frac=0, carry=0, sticky=0.
//  - Non-normalised inputs (MSB 0) are legal.
//    - Exact product still formed; window is selected as above.
//    - frac MSB may then be 0; the caller handles it.
//  - RST low mid-operation: immediate abort to the reset values above; partial result discarded.
// CONFIGURATION
//  - FRAC_MULT_STICKY_EN defined: sticky = |(dropped bits) per the normalisation rule.
//    Registered, valid while done=1, for round-to-nearest-even in the caller.
//  - Not defined: sticky tied 0 and no OR-reduce logic; port list unchanged.
// STRUCTURE
//  - Package frac_mult_pkg:
//    - state enum {IDLE, RUN, DONE}.
//    - CNT_W = $clog2(WIDTH+1).
//    - Helper function for product window selection.
//  - Sub-module adder_nbit #(N): ripple/CPA adder with Cout.
//    - Instantiated twice: 2*WIDTH accumulator add and CNT_W counter decrement.
// TESTING
//  - WIDTH=24: A=B=24'h800000 (1.0*1.0), start 1 cycle -> done at cycle 25.
//    Expect frac=24'h800000, carry=0, sticky=0.
//  - A=B=24'hC00000 (1.5*1.5) -> frac=24'h900000, carry=1, sticky=0.
//  - A=B=24'hFFFFFF -> P=48'hFFFFFE000001.
//    Expect frac=24'hFFFFFE, carry=1; sticky=1 with FRAC_MULT_STICKY_EN, else 0.
//  - Pulse start again at cycles 5 and 10 with new operands -> ignored; first result unchanged.
//    Then issue start the same cycle done rises -> second result done 25 cycles later.
//  - RST low at cycle 12 of a run -> all outputs 0 in that cycle.
//    After release, new start A=24'hA00000, B=24'h800000 -> frac=24'hA00000, carry=0.
//  - WIDTH=11: A=B=11'h7FF -> frac=11'h7FE, carry=1, done at cycle 12.
//    Also random compare against a 2*WIDTH reference product, 1000 vectors.

Source files
------------

// File: rtl/frac_mult_pkg.sv
// Shared types and helpers for the iterative significand multiplier.
// Optional FRAC_MULT_STICKY_EN adds the dropped-bit OR reduction helper.
package frac_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest significand the window helpers handle (double precision fits).
    localparam int unsigned MAX_W = 64;
    localparam int unsigned PMAX  = 2 * MAX_W;

    typedef struct packed {
        logic [MAX_W-1:0] frac;
        logic             carry;
    } norm_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Pick the W-bit significand window from a 2W-bit product.
    function automatic norm_t norm_window(input logic [PMAX-1:0] p, input int unsigned w);
        norm_t           r;
        logic [PMAX-1:0] q;
        r.carry = p[2*w-1];
        q       = r.carry ? (p >> w) : (p >> (w - 1));
        r.frac  = q[MAX_W-1:0];
        return r;
    endfunction

`ifdef FRAC_MULT_STICKY_EN
    // OR of the product bits that fall below the selected window.
    function automatic logic drop_or(input logic [PMAX-1:0] p, input int unsigned w);
        logic [PMAX-1:0] mask;
        int unsigned     sh;
        sh   = p[2*w-1] ? w : (w - 1);
        mask = (PMAX'(1) << sh) - PMAX'(1);
        return |(p & mask);
    endfunction
`endif

endpackage

// File: rtl/adder_nbit.sv
// N-bit ripple-carry adder with carry in/out.
module adder_nbit #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < int'(N); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_frac_mult.sv
// Iterative MSB-first shift-add significand multiplier with start/busy/done handshake.
// Define FRAC_MULT_STICKY_EN to produce the sticky (dropped-bit OR) output.
module seq_frac_mult
    import frac_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] frac,
    output logic             carry,
    output logic             sticky
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   frac_q, frac_d;
    logic               carry_q, carry_d;

    logic [PW-1:0]      acc_shl;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      acc_sum;
    logic [CNT_W-1:0]   cnt_dec;
    logic               acc_cout_unused;
    logic               cnt_cout_unused;
    norm_t              win;

    assign acc_shl = PW'(acc_q << 1);
    assign addend  = a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0;

    adder_nbit #(.N(PW)) u_acc_add (
        .a    (acc_shl),
        .b    (addend),
        .cin  (1'b0),
        .sum  (acc_sum),
        .cout (acc_cout_unused)
    );

    // Decrement as cnt + all-ones.
    adder_nbit #(.N(CNT_W)) u_cnt_dec (
        .a    (cnt_q),
        .b    ({CNT_W{1'b1}}),
        .cin  (1'b0),
        .sum  (cnt_dec),
        .cout (cnt_cout_unused)
    );

    assign win = norm_window(PMAX'(acc_sum), WIDTH);

`ifdef FRAC_MULT_STICKY_EN
    logic sticky_q, sticky_d;
    logic drop_any;
    assign drop_any = drop_or(PMAX'(acc_sum), WIDTH);
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        frac_d  = frac_q;
        carry_d = carry_q;
`ifdef FRAC_MULT_STICKY_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                a_d   = WIDTH'(a_q << 1);
                cnt_d = cnt_dec;
                // Last step: latch the normalised window of the final sum.
                if (cnt_dec == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    frac_d  = WIDTH'(win.frac);
                    carry_d = win.carry;
`ifdef FRAC_MULT_STICKY_EN
                    sticky_d = drop_any;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            frac_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            frac_q  <= frac_d;
            carry_q <= carry_d;
        end
    end

`ifdef FRAC_MULT_STICKY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) sticky_q <= 1'b0;
        else      sticky_q <= sticky_d;
    end
    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign frac  = frac_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_seq_frac_mult.sv
// Directed and random checks of seq_frac_mult at WIDTH=24 and WIDTH=11.
module tb_seq_frac_mult;

`ifdef FRAC_MULT_STICKY_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        s24, busy24, done24, carry24, sticky24;
    logic [23:0] a24, b24, frac24;
    logic        s11, busy11, done11, carry11, sticky11;
    logic [10:0] a11, b11, frac11;

    int total = 0;
    int bad   = 0;
    int cyc;

    seq_frac_mult #(.WIDTH(24)) u_dut24 (
        .CLK(clk), .RST(rst_n), .start(s24), .A(a24), .B(b24),
        .busy(busy24), .done(done24), .frac(frac24), .carry(carry24), .sticky(sticky24)
    );

    seq_frac_mult #(.WIDTH(11)) u_dut11 (
        .CLK(clk), .RST(rst_n), .start(s11), .A(a11), .B(b11),
        .busy(busy11), .done(done11), .frac(frac11), .carry(carry11), .sticky(sticky11)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference for WIDTH=11: {carry, sticky, frac}.
    function automatic logic [12:0] ref11(input logic [10:0] a, input logic [10:0] b);
        logic [21:0] p;
        logic [10:0] f;
        logic        st;
        p = 22'(a) * 22'(b);
        if (p[21]) begin
            f  = p[21:11];
            st = |p[10:0];
        end else begin
            f  = p[20:10];
            st = |p[9:0];
        end
        return {p[21], st & STK_EN, f};
    endfunction

    task automatic launch24(input logic [23:0] a, input logic [23:0] b);
        s24 = 1'b1; a24 = a; b24 = b;
        @(posedge clk); #1;
        s24 = 1'b0;
    endtask

    task automatic wait24(output int n);
        n = 1;
        while (!done24 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic launch11(input logic [10:0] a, input logic [10:0] b);
        s11 = 1'b1; a11 = a; b11 = b;
        @(posedge clk); #1;
        s11 = 1'b0;
    endtask

    task automatic wait11(output int n);
        n = 1;
        while (!done11 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        logic [10:0] ra, rb;
        logic [12:0] rexp;
        rst_n = 1'b0;
        s24 = 1'b0; a24 = '0; b24 = '0;
        s11 = 1'b0; a11 = '0; b11 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy24),   64'(0));
        chk("rst_done",   64'(done24),   64'(0));
        chk("rst_frac",   64'(frac24),   64'(0));
        chk("rst_carry",  64'(carry24),  64'(0));
        chk("rst_sticky", 64'(sticky24), 64'(0));
        chk("rst_frac11", 64'(frac11),   64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 * 1.0
        launch24(24'h800000, 24'h800000);
        chk("acc_busy", 64'(busy24), 64'(1));
        chk("acc_done", 64'(done24), 64'(0));
        wait24(cyc);
        chk("lat_1x1",    64'(cyc),      64'(25));
        chk("busy_end",   64'(busy24),   64'(0));
        chk("frac_1x1",   64'(frac24),   64'h800000);
        chk("carry_1x1",  64'(carry24),  64'(0));
        chk("sticky_1x1", 64'(sticky24), 64'(0));

        // 1.5 * 1.5
        launch24(24'hC00000, 24'hC00000);
        wait24(cyc);
        chk("frac_15",   64'(frac24),   64'h900000);
        chk("carry_15",  64'(carry24),  64'(1));
        chk("sticky_15", 64'(sticky24), 64'(0));

        // all-ones
        launch24(24'hFFFFFF, 24'hFFFFFF);
        wait24(cyc);
        chk("frac_ff",   64'(frac24),   64'hFFFFFE);
        chk("carry_ff",  64'(carry24),  64'(1));
        chk("sticky_ff", 64'(sticky24), 64'(STK_EN));

        // zero operand; previous result must hold while running
        launch24(24'h000000, 24'hFFFFFF);
        chk("hold_frac", 64'(frac24), 64'hFFFFFE);
        chk("hold_done", 64'(done24), 64'(0));
        wait24(cyc);
        chk("lat_zero",    64'(cyc),      64'(25));
        chk("frac_zero",   64'(frac24),   64'(0));
        chk("carry_zero",  64'(carry24),  64'(0));
        chk("sticky_zero", 64'(sticky24), 64'(0));

        // starts at cycles 5 and 10 are ignored
        launch24(24'hC00000, 24'hC00000);
        for (int c = 1; c < 25; c++) begin
            s24 = (c == 5 || c == 10);
            if (s24) begin
                a24 = 24'hFFFFFF; b24 = 24'hFFFFFF;
            end
            @(posedge clk); #1;
        end
        s24 = 1'b0;
        chk("ign_done",  64'(done24),  64'(1));
        chk("ign_frac",  64'(frac24),  64'h900000);
        chk("ign_carry", 64'(carry24), 64'(1));

        // start in the cycle done rises
        launch24(24'h800000, 24'hC00000);
        chk("b2b_done", 64'(done24), 64'(0));
        chk("b2b_busy", 64'(busy24), 64'(1));
        chk("b2b_hold", 64'(frac24), 64'h900000);
        wait24(cyc);
        chk("b2b_lat",   64'(cyc),     64'(25));
        chk("b2b_frac",  64'(frac24),  64'hC00000);
        chk("b2b_carry", 64'(carry24), 64'(0));

        // reset in cycle 12 of a run
        launch24(24'hFFFFFF, 24'hFFFFFF);
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy24),  64'(0));
        chk("mid_rst_done",  64'(done24),  64'(0));
        chk("mid_rst_frac",  64'(frac24),  64'(0));
        chk("mid_rst_carry", 64'(carry24), 64'(0));
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        launch24(24'hA00000, 24'h800000);
        wait24(cyc);
        chk("post_rst_lat",   64'(cyc),     64'(25));
        chk("post_rst_frac",  64'(frac24),  64'hA00000);
        chk("post_rst_carry", 64'(carry24), 64'(0));

        // WIDTH=11 all-ones
        launch11(11'h7FF, 11'h7FF);
        wait11(cyc);
        chk("lat_11",    64'(cyc),      64'(12));
        chk("frac_11",   64'(frac11),   64'h7FE);
        chk("carry_11",  64'(carry11),  64'(1));
        chk("sticky_11", 64'(sticky11), 64'(STK_EN));

        // random back-to-back vectors at WIDTH=11
        for (int i = 0; i < 1000; i++) begin
            ra = 11'($urandom);
            rb = 11'($urandom);
            rexp = ref11(ra, rb);
            launch11(ra, rb);
            wait11(cyc);
            chk("rnd11", 64'({carry11, sticky11, frac11}), 64'(rexp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
